// File: rtl/arbitro_memoria_dados_pkg.sv
// pkg_memoria: shared constants and FSM encoding for the data-memory arbiter.
`default_nettype none

package pkg_memoria;

    localparam int RAM_SIZE = 150;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/arbitro_memoria_dados_arb_rr2.sv
// arb_rr2: two-way conflict picker, round-robin against last winner or fixed port-0 priority.
`default_nettype none

module arb_rr2
    import pkg_memoria::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic pick
);

    always_comb begin
        pick = PORT0;
        if (req0 && req1) begin
            pick = (FIXED_PRI != 0) ? PORT0 : ~last_gnt;
        end else if (req1) begin
            pick = PORT1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados: shares the single-port data memory between CPU (port 0) and DMA (port 1).
`default_nettype none

module arbitro_memoria_dados
    import pkg_memoria::*;
#(
    parameter int RAM_SIZE  = pkg_memoria::RAM_SIZE,
    parameter int DATA_W    = pkg_memoria::DATA_W,
    parameter int ADDR_W    = pkg_memoria::ADDR_W,
    parameter int MAX_BURST = 8,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W      = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  BURST_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(RAM_SIZE);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   burst_cnt, burst_nx;
    logic               last_gnt;
    logic               pick;
    logic               use_arb;
    logic               oor0, oor1;
    logic               rvalid0_q, rvalid1_q;
    logic               err0_q, err1_q;

    assign oor0 = (addr0 >= ADDR_LIMIT);
    assign oor1 = (addr1 >= ADDR_LIMIT);

    arb_rr2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .pick     (pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last_gnt  <= PORT1;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
            if (gnt0 || gnt1) begin
                last_gnt <= gnt1;
            end
        end
    end

    // A locked owner keeps the port until it drops req/lock or the waiting port's burst quota expires.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        state_nx = state;
        burst_nx = burst_cnt;
        use_arb  = 1'b0;
        case (state)
            OWN0: begin
                if (req0) begin
                    if (req1 && burst_cnt == BURST_MAX) begin
                        gnt1     = 1'b1;
                        state_nx = IDLE;
                        burst_nx = '0;
                    end else begin
                        gnt0 = 1'b1;
                        if (!lock0) begin
                            state_nx = IDLE;
                            burst_nx = '0;
                        end else if (req1 && burst_cnt < BURST_MAX) begin
                            burst_nx = burst_cnt + BURST_ONE;
                        end
                    end
                end else begin
                    use_arb = 1'b1;
                end
            end
            OWN1: begin
                if (req1) begin
                    if (req0 && burst_cnt == BURST_MAX) begin
                        gnt0     = 1'b1;
                        state_nx = IDLE;
                        burst_nx = '0;
                    end else begin
                        gnt1 = 1'b1;
                        if (!lock1) begin
                            state_nx = IDLE;
                            burst_nx = '0;
                        end else if (req0 && burst_cnt < BURST_MAX) begin
                            burst_nx = burst_cnt + BURST_ONE;
                        end
                    end
                end else begin
                    use_arb = 1'b1;
                end
            end
            default: use_arb = 1'b1;
        endcase

        if (use_arb) begin
            state_nx = IDLE;
            burst_nx = '0;
            if (req0 || req1) begin
                if (pick == PORT1) begin
                    gnt1 = 1'b1;
                    if (lock1) begin
                        state_nx = OWN1;
                        burst_nx = BURST_ONE;
                    end
                end else begin
                    gnt0 = 1'b1;
                    if (lock0) begin
                        state_nx = OWN0;
                        burst_nx = BURST_ONE;
                    end
                end
            end
        end

        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Out-of-range accesses are still granted but must never reach the memory as writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = we0 & ~oor0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_we    = we1 & ~oor1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            rvalid0_q <= gnt0 && (oor0 || !we0);
            rvalid1_q <= gnt1 && (oor1 || !we1);
            err0_q    <= gnt0 && oor0;
            err1_q    <= gnt1 && oor1;
            if (gnt0 && oor0) begin
                rdata0 <= '0;
            end else if (gnt0 && !we0) begin
                rdata0 <= mem_rdata;
            end
            if (gnt1 && oor1) begin
                rdata1 <= '0;
            end else if (gnt1 && !we1) begin
                rdata1 <= mem_rdata;
            end
        end
    end

    // A reset arriving while a return is pending suppresses that return immediately.
    assign rvalid0 = rvalid0_q & ~reset;
    assign rvalid1 = rvalid1_q & ~reset;
    assign err0    = err0_q & ~reset;
    assign err1    = err1_q & ~reset;

endmodule

`default_nettype wire
